// File: rtl/pipeline_freeze_ctrl_pkg.sv
// Shared pipeline-control definitions: action encodings, bubble instruction
// and the opcode constants also used by the hazard detector.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        CTRL_RUN        = 2'd0,
        CTRL_LOAD_STALL = 2'd1,
        CTRL_MEM_WAIT   = 2'd2,
        CTRL_FLUSH      = 2'd3
    } ctrl_state_e;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

endpackage

// File: rtl/pipeline_freeze_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next value: step unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_freeze_ctrl.sv
// PC / IF-ID owner that freezes, flushes or bubbles the front end
// on memory waits, taken branches and load-use stalls.
module pipeline_freeze_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = pipe_ctrl_pkg::NOP_INSN,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_req,
    input  logic             mem_busy,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic [31:0]      imem_instruction,
    output logic [31:0]      pc,
    output logic [31:0]      ifid_instruction,
    output logic [31:0]      ifid_pc,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    ctrl_state_e action;
    ctrl_state_e state_q;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] ipc_q, ipc_d;
    logic        stall_inc;
    logic        flush_inc;

    // Fixed-priority arbitration: memory wait beats branch beats load-use.
    always_comb begin
        action = CTRL_RUN;
        priority case (1'b1)
            mem_busy:     action = CTRL_MEM_WAIT;
            branch_taken: action = CTRL_FLUSH;
            stall_req:    action = CTRL_LOAD_STALL;
            default:      action = CTRL_RUN;
        endcase
    end

    // Front-end next state for the chosen action.
    always_comb begin
        pc_d  = pc_q;
        ins_d = ins_q;
        ipc_d = ipc_q;
        unique case (action)
            CTRL_RUN: begin
                pc_d  = pc_q + 32'd4;
                ins_d = imem_instruction;
                ipc_d = pc_q;
            end
            CTRL_FLUSH: begin
                pc_d  = branch_target;
                ins_d = NOP_INSN;
                ipc_d = branch_target;
            end
            default: ;
        endcase
    end

    // PC, IF/ID and last-action registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            ins_q   <= NOP_INSN;
            ipc_q   <= RESET_PC;
            state_q <= CTRL_RUN;
        end else begin
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            ipc_q   <= ipc_d;
            state_q <= action;
        end
    end

    assign idex_bubble = !reset &&
        ((action == CTRL_FLUSH) || (action == CTRL_LOAD_STALL));
    assign pipe_hold   = !reset && (action == CTRL_MEM_WAIT);

    assign stall_inc = (action == CTRL_LOAD_STALL) ||
                       (action == CTRL_MEM_WAIT);
    assign flush_inc = (action == CTRL_FLUSH);

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_count)
    );

    assign pc               = pc_q;
    assign ifid_instruction = ins_q;
    assign ifid_pc          = ipc_q;
    assign ctrl_state       = state_q;

endmodule
